// File: rtl/lib_rr_arbiter_pkg.sv
// lib_arb_pkg: shared types and helpers for round-robin arbitration blocks.
package lib_arb_pkg;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    function automatic int rr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lib_rr_arbiter_if.sv
// lib_rr_arbiter_if: N:1 flit arbiter bundle; FIFO side valid/enable in, registered flit out.
interface lib_rr_arbiter_if
    import lib_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N*WIDTH-1:0]     i_data;
    logic [N-1:0]           i_data_val;
    logic [N-1:0]           o_en;
    logic [WIDTH-1:0]       o_data;
    logic                   o_data_val;
    logic                   i_en;
    logic [rr_width(N)-1:0] o_grant;

    modport slave (
        input  i_data, i_data_val, i_en,
        output o_en, o_data, o_data_val, o_grant
    );

    modport master (
        output i_data, i_data_val, i_en,
        input  o_en, o_data, o_data_val, o_grant
    );
endinterface

// File: rtl/lib_rr_arbiter_pick.sv
// lib_rr_pick: combinational round-robin picker; first request at or after ptr, wrapping.
module lib_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    // Scan from farthest to nearest offset so the nearest request wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[IW'((int'(ptr) + i) % N)]) idx = IW'((int'(ptr) + i) % N);
        end
    end

    assign any = |req;
    assign gnt = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/lib_rr_arbiter.sv
// lib_rr_arbiter: round-robin N:1 flit arbiter with registered output and optional packet lock.
module lib_rr_arbiter
    import lib_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int LOCK  = 0
) (
    input logic              clk,
    input logic              reset_n,
    lib_rr_arbiter_if.slave  bus
);
    localparam int IW       = rr_width(N);
    localparam int TAIL_BIT = WIDTH - 1;

    arb_state_t     state, state_nx;
    logic [IW-1:0]  ptr, lock_idx, g;
    logic [N-1:0]   req, gnt;
    logic [WIDTH-1:0] flit;
    logic           any, load_ok, grant, tail;

    assign load_ok = ~bus.o_data_val | bus.i_en;
    // While locked only the owning input may compete.
    assign req     = (state == LOCKED) ? (bus.i_data_val & (N'(1) << lock_idx)) : bus.i_data_val;

    lib_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (g),
        .any (any)
    );

    assign grant    = reset_n & load_ok & any;
    assign bus.o_en = grant ? gnt : '0;
    assign flit     = bus.i_data[int'(g)*WIDTH +: WIDTH];
    assign tail     = (LOCK == 0) | flit[TAIL_BIT];

    always_comb begin
        state_nx = state;
        if (grant && LOCK != 0) state_nx = tail ? ARB : LOCKED;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ARB;
            ptr            <= '0;
            lock_idx       <= '0;
            bus.o_data     <= '0;
            bus.o_data_val <= 1'b0;
            bus.o_grant    <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                bus.o_data  <= flit;
                bus.o_grant <= g;
                lock_idx    <= g;
                if (tail) ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
            end
            if (load_ok) bus.o_data_val <= any;
        end
    end
endmodule

// File: tb/tb_lib_rr_arbiter.sv
// tb_lib_rr_arbiter: directed vectors for per-flit mode plus hand sequences for packet lock.
module tb_lib_rr_arbiter;
    import lib_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    lib_rr_arbiter_if #(.N(4), .WIDTH(8)) b0 ();
    lib_rr_arbiter_if #(.N(4), .WIDTH(8)) b1 ();

    lib_rr_arbiter #(.N(4), .WIDTH(8), .LOCK(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
    lib_rr_arbiter #(.N(4), .WIDTH(8), .LOCK(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));

    typedef struct {
        logic [3:0] val;
        logic       en;
        logic [3:0] x_en;
        logic       x_dv;
        logic [7:0] x_data;
        logic [1:0] x_grant;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string nm, input int id, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, id, a, e);
        end
    endtask

    task automatic chk0(input string nm, input int id, input logic [3:0] xen, input logic xdv,
                        input logic [7:0] xd, input logic [1:0] xg);
        chk({nm, ".o_en"}, id, 32'(b0.o_en), 32'(xen));
        chk({nm, ".o_data_val"}, id, 32'(b0.o_data_val), 32'(xdv));
        chk({nm, ".o_data"}, id, 32'(b0.o_data), 32'(xd));
        chk({nm, ".o_grant"}, id, 32'(b0.o_grant), 32'(xg));
    endtask

    task automatic chk1(input string nm, input int id, input logic [3:0] xen, input logic xdv,
                        input logic [7:0] xd, input logic [1:0] xg);
        chk({nm, ".o_en"}, id, 32'(b1.o_en), 32'(xen));
        chk({nm, ".o_data_val"}, id, 32'(b1.o_data_val), 32'(xdv));
        chk({nm, ".o_data"}, id, 32'(b1.o_data), 32'(xd));
        chk({nm, ".o_grant"}, id, 32'(b1.o_grant), 32'(xg));
    endtask

    // Drive lock-mode inputs, check before the next edge, then take the edge.
    task automatic step1(input int id, input logic [3:0] val, input logic [31:0] data,
                         input logic [3:0] xen, input logic xdv, input logic [7:0] xd, input logic [1:0] xg);
        b1.i_data_val = val;
        b1.i_data     = data;
        @(negedge clk);
        chk1("lock", id, xen, xdv, xd, xg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
        vec[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
        vec[2]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vec[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vec[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vec[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h20, 2'd1};
        vec[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h30, 2'd2};
        vec[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h40, 2'd3};
        vec[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0};
        vec[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
        vec[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0};
        vec[11] = '{4'b1000, 1'b0, 4'b1000, 1'b0, 8'h10, 2'd0};
        vec[12] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h40, 2'd3};
        vec[13] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 8'h40, 2'd3};
        vec[14] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 8'h10, 2'd0};
        vec[15] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 8'h30, 2'd2};
        vec[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0};
        vec[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};

        b0.i_data = 32'h40302010;
        b0.i_data_val = 4'b1111;
        b0.i_en = 1'b1;
        b1.i_data = 32'h0;
        b1.i_data_val = 4'b1111;
        b1.i_en = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk0("rst", 0, 4'b0000, 1'b0, 8'h00, 2'd0);
        chk1("rst", 0, 4'b0000, 1'b0, 8'h00, 2'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        b1.i_data_val = 4'b0000;

        foreach (vec[i]) begin
            b0.i_data_val = vec[i].val;
            b0.i_en = vec[i].en;
            @(negedge clk);
            chk0("vec", i, vec[i].x_en, vec[i].x_dv, vec[i].x_data, vec[i].x_grant);
            @(posedge clk);
            #1;
        end
        b0.i_data_val = 4'b0000;

        // Single-flit packet from input 0 moves the pointer to 1.
        step1(0, 4'b0001, 32'h00_00_00_80, 4'b0001, 1'b0, 8'h00, 2'd0);
        step1(1, 4'b0110, 32'h00_05_01_00, 4'b0010, 1'b1, 8'h80, 2'd0);
        step1(2, 4'b0110, 32'h00_05_02_00, 4'b0010, 1'b1, 8'h01, 2'd1);
        // Locked input drops valid: bubble, inputs 2/3 must stay unserved.
        step1(3, 4'b1100, 32'h07_05_00_00, 4'b0000, 1'b1, 8'h02, 2'd1);
        step1(4, 4'b1100, 32'h07_05_00_00, 4'b0000, 1'b0, 8'h02, 2'd1);
        step1(5, 4'b0110, 32'h07_05_83_00, 4'b0010, 1'b0, 8'h02, 2'd1);
        step1(6, 4'b0100, 32'h07_05_00_00, 4'b0100, 1'b1, 8'h83, 2'd1);
        step1(7, 4'b0000, 32'h07_05_00_00, 4'b0000, 1'b1, 8'h05, 2'd2);

        // Now locked on input 2; reset mid-packet must drop the lock.
        reset_n = 1'b0;
        b1.i_data_val = 4'b1111;
        @(negedge clk);
        chk("rst_mid.o_en", 0, 32'(b1.o_en), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step1(8, 4'b1000, 32'h80_00_00_00, 4'b1000, 1'b0, 8'h00, 2'd0);
        step1(9, 4'b1000, 32'h80_00_00_00, 4'b1000, 1'b1, 8'h80, 2'd3);
        step1(10, 4'b1000, 32'h81_00_00_00, 4'b1000, 1'b1, 8'h80, 2'd3);
        step1(11, 4'b0000, 32'h00_00_00_00, 4'b0000, 1'b1, 8'h81, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lib_rr_arbiter.md
Name: lib_rr_arbiter

Overview:
Round-robin N:1 output arbiter that consumes flits from N upstream synchronous FIFOs and drives a single registered output toward the next router or link stage. It uses the same valid/enable handshake as the FIFOs on both sides. With LOCK=1 it holds a grant for the whole packet, until the tail flit passes, so multi-flit packets are never interleaved. It sits directly downstream of the per-input FIFOs in a router output port.

Parameters:
N, 4, number of input FIFOs; N >= 2.
WIDTH, 8, flit width in bits.
LOCK, 0, 1 = packet lock (bit WIDTH-1 of a flit is the tail flag); 0 = per-flit arbitration.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
i_data  in  N*WIDTH  packed flits; input k occupies bits [k*WIDTH +: WIDTH]
i_data_val  in  N  per-input valid (driven by the FIFO's data-valid output)
o_en  out  N  one-hot read acknowledge; high on an edge = that input's flit consumed (drives the FIFO's read enable)
o_data  out  WIDTH  registered output flit
o_data_val  out  1  o_data valid; held until consumed
i_en  in  1  downstream enable; high on an edge while o_data_val = o_data consumed
o_grant  out  $clog2(N)  index of the input that supplied the current o_data

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Reset values: o_data=0, o_data_val=0, o_grant=0, round-robin pointer=0, state=ARB, o_en=0 (combinational, forced 0 while reset_n=0).
- Load condition: `load_ok = ~o_data_val | i_en`, meaning the output register is empty or is being drained this cycle.
- Candidate set:
  - ARB state: all k with i_data_val[k].
  - LOCKED state: only the locked index, and only if its i_data_val is high.
- Selection in ARB: first candidate at or after the pointer, searching pointer, pointer+1, ... and wrapping N-1 -> 0.
- Grant: o_en[g] = load_ok & candidate exists. It is combinational and one-hot, with at most one bit set per cycle.
- On a grant edge:
  - o_data <= i_data[g]; o_data_val <= 1; o_grant <= g.
  - Latency: input valid to o_data_val is 1 cycle.
  - Throughput: 1 flit/cycle when i_en is held high.
- On `load_ok` with no candidate: o_data_val <= 0 (if it was being drained); o_data holds its last value.
- Downstream stall (o_data_val=1, i_en=0): o_data, o_grant and o_data_val held stable; o_en=0. FIFOs are not read.
- Pointer update: on each grant where the granted flit ends arbitration, pointer <= (g+1) mod N. A flit ends arbitration when LOCK=0, or when LOCK=1 and its tail bit is set. Otherwise the pointer is unchanged.
- FSM (LOCK=1 only; with LOCK=0 the state stays ARB):
  - ARB -> LOCKED on a grant of a flit with bit WIDTH-1 = 0; the lock index is g.
  - LOCKED -> ARB on a grant of a flit with bit WIDTH-1 = 1.
  - LOCKED, locked input not valid: insert a bubble and stay LOCKED; other inputs are ignored.
  - A single-flit packet (tail bit set) granted from ARB stays in ARB.
- Simultaneous drain and load in the same edge: legal, and is the normal full-rate case.
- Reset mid-packet: lock dropped; state=ARB, pointer=0; output invalidated.
- Never assert o_en[k] when i_data_val[k]=0.

Decomposition:
- Package lib_arb_pkg:
  - state enum {ARB, LOCKED}
  - function rr_index width, `$clog2(N)`
  - localparam TAIL_BIT = WIDTH-1
- Sub-module lib_rr_pick:
  - Combinational; inputs: request vector N and pointer.
  - Outputs: one-hot grant, binary index, any-request flag.
  - Reused by later switch allocators.
- Top level holds the FSM, pointer, lock index and output register.

Test Plan:
1. Reset with i_data_val=1111 -> o_data_val=0, o_en=0000, o_grant=0 during and one cycle after reset.
2. LOCK=0, N=4, all valid, inputs hold 0x10/0x20/0x30/0x40, i_en=1 constant -> o_en cycles 0001,0010,0100,1000,0001; o_data 0x10,0x20,0x30,0x40,0x10 on consecutive cycles.
3. o_data_val=1 (0x20), i_en=0 for 3 cycles -> o_data=0x20 held, o_en=0000 throughout; on i_en=1, the next grant goes to input 2.
4. LOCK=1: input 1 presents 0x01,0x02,0x83; input 2 holds 0x05, pointer=1 -> output 0x01,0x02,0x83 all with o_grant=1, then 0x05 with o_grant=2; no interleave.
5. LOCK=1, locked to input 1 after 0x01; input 1 val drops for 2 cycles while input 3 is valid -> o_en[3] never asserted, o_data_val=0 bubble; resumes with input 1's 0x83.
6. Only input 3 valid, i_en=1 -> grant every cycle to input 3 (pointer wraps 3 -> 0 -> search finds 3); assert reset_n=0 mid-LOCKED -> o_data_val=0, state ARB on release.
